// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// instruction size, default memory size and latency-counter width.
package inst_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT,
        S_ERR
    } state_t;

    localparam int unsigned INST_BYTES         = 4;
    localparam int unsigned DEFAULT_IMEM_BYTES = 4096;
    localparam int unsigned LAT_CNT_W          = 3;

endpackage

// File: rtl/inst_fetch_ctrl_next_pc_gen.sv
// Next-PC selection (sequential or branch) with wrap-around increment and
// legality check against instruction alignment and memory size.
module next_pc_gen
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  branch_sel,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  illegal
);

    localparam logic [ADDR_WIDTH-1:0] MAX_PC = ADDR_WIDTH'(IMEM_BYTES - INST_BYTES);

    logic [ADDR_WIDTH-1:0] seq_pc;

    // Carry out of the increment is dropped; a wrapped PC is judged by the same rule.
    assign seq_pc  = pc + ADDR_WIDTH'(INST_BYTES);
    assign next_pc = branch_sel ? branch_target : seq_pc;
    assign illegal = (next_pc[1:0] != 2'b00) || (next_pc > MAX_PC);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller upstream of the PC register: request, wait fixed latency,
// hold the instruction for execute, then update the PC or stop on halt/error.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMEM_LAT   = 1,
    parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_pc_en,
    output logic [ADDR_WIDTH-1:0] o_next_pc,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_inst_valid,
    input  logic                  i_exec_done,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic                  i_halt,
    output logic                  o_halted,
    output logic                  o_addr_err
);

    state_t                 state;
    state_t                 state_nx;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [DATA_WIDTH-1:0]  inst_q;
    logic                   accept;
    logic                   npc_illegal;

    assign accept      = (state == S_ISSUE) && i_exec_done;
    assign o_imem_addr = i_pc;
    assign o_inst      = inst_q;

    // Branch inputs only matter in the accepting cycle; otherwise this is pc+4.
    next_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next_pc_gen (
        .pc            (i_pc),
        .branch_sel    (accept && i_branch_taken),
        .branch_target (i_branch_target),
        .next_pc       (o_next_pc),
        .illegal       (npc_illegal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            inst_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_REQ) begin
                lat_cnt <= LAT_CNT_W'(IMEM_LAT - 1);
            end else if (state == S_WAIT) begin
                if (lat_cnt == '0) begin
                    inst_q <= i_imem_rdata;
                end else begin
                    lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx     = state;
        o_pc_en      = 1'b0;
        o_imem_req   = 1'b0;
        o_inst_valid = 1'b0;
        o_halted     = 1'b0;
        o_addr_err   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                o_imem_req = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_inst_valid = 1'b1;
                if (i_exec_done) begin
                    if (i_halt) begin
                        state_nx = S_HALT;
                    end else if (npc_illegal) begin
                        state_nx = S_ERR;
                    end else begin
                        o_pc_en  = 1'b1;
                        state_nx = S_REQ;
                    end
                end
            end
            S_HALT:  o_halted   = 1'b1;
            S_ERR:   o_addr_err = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: two instances (IMEM_LAT=1 and 3), each
// driven by a small PC-register model that loads o_next_pc on o_pc_en.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst_n     [2];
    logic [31:0] pc        [2];
    logic        pc_en     [2];
    logic [31:0] next_pc   [2];
    logic        req       [2];
    logic [31:0] imem_addr [2];
    logic [31:0] rdata     [2];
    logic [31:0] inst      [2];
    logic        valid     [2];
    logic        exec_done [2];
    logic        br        [2];
    logic [31:0] target    [2];
    logic        halt      [2];
    logic        halted    [2];
    logic        err       [2];

    logic        pc_wr     [2];
    logic [31:0] pc_wval   [2];

    int tests  = 0;
    int failed = 0;

    inst_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .IMEM_LAT   (1),
        .IMEM_BYTES (4096)
    ) u_dut_lat1 (
        .i_clk           (clk),
        .i_rst_n         (rst_n[0]),
        .i_pc            (pc[0]),
        .o_pc_en         (pc_en[0]),
        .o_next_pc       (next_pc[0]),
        .o_imem_req      (req[0]),
        .o_imem_addr     (imem_addr[0]),
        .i_imem_rdata    (rdata[0]),
        .o_inst          (inst[0]),
        .o_inst_valid    (valid[0]),
        .i_exec_done     (exec_done[0]),
        .i_branch_taken  (br[0]),
        .i_branch_target (target[0]),
        .i_halt          (halt[0]),
        .o_halted        (halted[0]),
        .o_addr_err      (err[0])
    );

    inst_fetch_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .IMEM_LAT   (3),
        .IMEM_BYTES (4096)
    ) u_dut_lat3 (
        .i_clk           (clk),
        .i_rst_n         (rst_n[1]),
        .i_pc            (pc[1]),
        .o_pc_en         (pc_en[1]),
        .o_next_pc       (next_pc[1]),
        .o_imem_req      (req[1]),
        .o_imem_addr     (imem_addr[1]),
        .i_imem_rdata    (rdata[1]),
        .o_inst          (inst[1]),
        .o_inst_valid    (valid[1]),
        .i_exec_done     (exec_done[1]),
        .i_branch_taken  (br[1]),
        .i_branch_target (target[1]),
        .i_halt          (halt[1]),
        .o_halted        (halted[1]),
        .o_addr_err      (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model; pc_wr lets the bench preset the PC.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pc_wr[k])
                pc[k] <= pc_wval[k];
            else if (pc_en[k])
                pc[k] <= next_pc[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input int k, input logic [31:0] v);
        pc_wval[k] = v;
        pc_wr[k]   = 1'b1;
        tick();
        pc_wr[k]   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 1'b0;
            rdata[k]     = '0;
            exec_done[k] = 1'b0;
            br[k]        = 1'b0;
            target[k]    = '0;
            halt[k]      = 1'b0;
            pc_wr[k]     = 1'b0;
            pc_wval[k]   = '0;
        end
        rdata[0] = 32'h0050_0093;
        set_pc(0, 32'h0);
        set_pc(1, 32'h20);
        tick();

        // Reset values
        check("rst_pc_en",  32'(pc_en[0]),  32'h0);
        check("rst_req",    32'(req[0]),    32'h0);
        check("rst_inst",   inst[0],        32'h0);
        check("rst_valid",  32'(valid[0]),  32'h0);
        check("rst_halted", 32'(halted[0]), 32'h0);
        check("rst_err",    32'(err[0]),    32'h0);
        check("rst_next_pc", next_pc[0],    32'h4);

        // Startup timing, IMEM_LAT=1
        rst_n[0] = 1'b1;
        check("c0_req", 32'(req[0]), 32'h0);
        tick();
        check("c1_req",  32'(req[0]), 32'h1);
        check("c1_addr", imem_addr[0], 32'h0);
        tick();
        check("c2_req",   32'(req[0]),   32'h0);
        check("c2_valid", 32'(valid[0]), 32'h0);
        tick();
        check("c3_valid", 32'(valid[0]), 32'h1);
        check("c3_inst",  inst[0],       32'h0050_0093);

        // Instruction held while waiting on execute
        rdata[0] = 32'hDEAD_BEEF;
        set_pc(0, 32'h10);
        check("hold_inst",  inst[0],       32'h0050_0093);
        check("hold_valid", 32'(valid[0]), 32'h1);

        // Sequential
        exec_done[0] = 1'b1;
        #1;
        check("seq_pc_en",   32'(pc_en[0]), 32'h1);
        check("seq_next_pc", next_pc[0],    32'h14);
        tick();
        exec_done[0] = 1'b0;
        rdata[0] = 32'h1111_1111;
        check("seq_req",       32'(req[0]),   32'h1);
        check("seq_addr",      imem_addr[0],  32'h14);
        check("seq_pc_en_off", 32'(pc_en[0]), 32'h0);
        check("seq_valid_off", 32'(valid[0]), 32'h0);
        tick();
        tick();
        check("seq_inst", inst[0], 32'h1111_1111);

        // Branch
        set_pc(0, 32'h20);
        exec_done[0] = 1'b1;
        br[0]        = 1'b1;
        target[0]    = 32'h40;
        #1;
        check("br_pc_en",   32'(pc_en[0]), 32'h1);
        check("br_next_pc", next_pc[0],    32'h40);
        tick();
        exec_done[0] = 1'b0;
        br[0]        = 1'b0;
        check("br_addr", imem_addr[0], 32'h40);
        tick();
        tick();
        check("br_valid", 32'(valid[0]), 32'h1);

        // Halt wins over branch
        exec_done[0] = 1'b1;
        halt[0]      = 1'b1;
        br[0]        = 1'b1;
        target[0]    = 32'h80;
        #1;
        check("halt_pc_en", 32'(pc_en[0]), 32'h0);
        tick();
        exec_done[0] = 1'b0;
        halt[0]      = 1'b0;
        br[0]        = 1'b0;
        check("halt_halted", 32'(halted[0]), 32'h1);
        check("halt_valid",  32'(valid[0]),  32'h0);
        check("halt_req",    32'(req[0]),    32'h0);
        tick();
        check("halt_sticky", 32'(halted[0]), 32'h1);
        check("halt_pc",     pc[0],          32'h40);

        // Misaligned branch target
        rst_n[0] = 1'b0;
        #1;
        check("rst_clr_halted", 32'(halted[0]), 32'h0);
        set_pc(0, 32'h30);
        rst_n[0] = 1'b1;
        tick();
        tick();
        tick();
        exec_done[0] = 1'b1;
        br[0]        = 1'b1;
        target[0]    = 32'h42;
        #1;
        check("mis_pc_en", 32'(pc_en[0]), 32'h0);
        tick();
        exec_done[0] = 1'b0;
        br[0]        = 1'b0;
        check("mis_err", 32'(err[0]), 32'h1);
        check("mis_req", 32'(req[0]), 32'h0);
        tick();
        check("mis_err_sticky", 32'(err[0]), 32'h1);
        check("mis_req_after",  32'(req[0]), 32'h0);

        // Wrap-around of pc+4 and top-of-memory boundary
        rst_n[0] = 1'b0;
        #1;
        check("rst_clr_err", 32'(err[0]), 32'h0);
        set_pc(0, 32'hFFFF_FFFC);
        rst_n[0] = 1'b1;
        tick();
        tick();
        tick();
        exec_done[0] = 1'b1;
        #1;
        check("wrap_pc_en",   32'(pc_en[0]), 32'h1);
        check("wrap_next_pc", next_pc[0],    32'h0);
        tick();
        exec_done[0] = 1'b0;
        check("wrap_addr", imem_addr[0], 32'h0);
        tick();
        tick();
        exec_done[0] = 1'b1;
        br[0]        = 1'b1;
        target[0]    = 32'hFFC;
        #1;
        check("top_pc_en",   32'(pc_en[0]), 32'h1);
        check("top_next_pc", next_pc[0],    32'hFFC);
        tick();
        exec_done[0] = 1'b0;
        br[0]        = 1'b0;
        tick();
        tick();
        exec_done[0] = 1'b1;
        br[0]        = 1'b1;
        target[0]    = 32'h1000;
        #1;
        check("oor_pc_en", 32'(pc_en[0]), 32'h0);
        tick();
        exec_done[0] = 1'b0;
        br[0]        = 1'b0;
        check("oor_err", 32'(err[0]), 32'h1);

        // IMEM_LAT=3 startup and 5-cycle loop
        rdata[1] = 32'hCAFE_F00D;
        rst_n[1] = 1'b1;
        tick();
        check("l3_req",  32'(req[1]),  32'h1);
        check("l3_addr", imem_addr[1], 32'h20);
        tick();
        tick();
        tick();
        check("l3_c4_valid", 32'(valid[1]), 32'h0);
        tick();
        check("l3_c5_valid", 32'(valid[1]), 32'h1);
        check("l3_inst",     inst[1],       32'hCAFE_F00D);
        exec_done[1] = 1'b1;
        br[1]        = 1'b1;
        target[1]    = 32'h40;
        #1;
        check("l3_br_next_pc", next_pc[1], 32'h40);
        tick();
        exec_done[1] = 1'b0;
        br[1]        = 1'b0;
        rdata[1]     = 32'h2222_3333;
        check("l3_loop_addr", imem_addr[1], 32'h40);
        tick();
        tick();
        tick();
        check("l3_loop_w3_valid", 32'(valid[1]), 32'h0);
        tick();
        check("l3_loop_valid", 32'(valid[1]), 32'h1);
        check("l3_loop_inst",  inst[1],       32'h2222_3333);

        // Reset during S_WAIT
        exec_done[1] = 1'b1;
        #1;
        check("l3_seq_pc_en", 32'(pc_en[1]), 32'h1);
        tick();
        exec_done[1] = 1'b0;
        tick();
        rst_n[1] = 1'b0;
        #1;
        check("mid_rst_req",   32'(req[1]),   32'h0);
        check("mid_rst_valid", 32'(valid[1]), 32'h0);
        check("mid_rst_inst",  inst[1],       32'h0);
        check("mid_rst_pc_en", 32'(pc_en[1]), 32'h0);
        tick();
        rst_n[1] = 1'b1;
        check("restart_idle_req", 32'(req[1]), 32'h0);
        tick();
        check("restart_req",  32'(req[1]),  32'h1);
        check("restart_addr", imem_addr[1], 32'h44);
        tick();
        tick();
        tick();
        tick();
        check("restart_valid", 32'(valid[1]), 32'h1);
        check("restart_pc",    pc[1],         32'h44);
        check("restart_pc_en", 32'(pc_en[1]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch controller that sits directly upstream of the PC register. It reads the current PC, issues an instruction-memory read, and waits a fixed memory latency. It then holds the fetched instruction for the execute stage and, once execution completes, computes the next PC (sequential or branch) and pulses the PC register's write enable. It also detects halt and illegal-target conditions and freezes fetch in those cases.

## Interface
- ADDR_WIDTH, 32, PC / memory address width
- DATA_WIDTH, 32, instruction width
- IMEM_LAT, 1, cycles from request to valid read data (1..7)
- IMEM_BYTES, 4096, instruction memory size in bytes; legal PCs are 0..IMEM_BYTES-4
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pc  in  ADDR_WIDTH  current PC from the PC register
- o_pc_en  out  1  PC register write enable; single-cycle pulse
- o_next_pc  out  ADDR_WIDTH  value the PC register loads when o_pc_en=1
- o_imem_req  out  1  instruction read request
- o_imem_addr  out  ADDR_WIDTH  read address (equals i_pc)
- i_imem_rdata  in  DATA_WIDTH  read data, valid IMEM_LAT cycles after the request
- o_inst  out  DATA_WIDTH  registered instruction
- o_inst_valid  out  1  o_inst is valid and held for execute
- i_exec_done  in  1  execute stage finished o_inst (sampled only in S_ISSUE)
- i_branch_taken  in  1  qualifies i_branch_target; sampled with i_exec_done
- i_branch_target  in  ADDR_WIDTH  branch/jump target
- i_halt  in  1  current instruction is end-of-program; sampled with i_exec_done
- o_halted  out  1  sticky; fetch stopped normally
- o_addr_err  out  1  sticky; fetch stopped on an illegal next PC

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_ISSUE, S_HALT, S_ERR.
- S_IDLE: entered on reset; lasts 1 cycle; then goes to S_REQ.
- S_REQ: o_imem_req=1 with o_imem_addr=i_pc; load the latency counter with IMEM_LAT-1; go to S_WAIT.
- S_WAIT: decrement the counter. When it reaches 0, capture i_imem_rdata into o_inst and go to S_ISSUE.
- S_ISSUE: o_inst_valid=1 and o_inst is held stable. When i_exec_done=1, resolve the next step in this priority order:
  1. i_halt=1: no o_pc_en; go to S_HALT.
  2. Next PC illegal: no o_pc_en; go to S_ERR.
  3. Otherwise: pulse o_pc_en for 1 cycle; go to S_REQ.
- Next PC: i_branch_taken ? i_branch_target : i_pc + 4. The addition wraps modulo 2^ADDR_WIDTH; the carry is dropped.
- Illegal next PC: next_pc[1:0]≠0, or next_pc > IMEM_BYTES-4. A wrapped pc+4 (e.g. 0xFFFFFFFC→0) is legal only by this same rule.
- i_halt, i_branch_taken and i_branch_target are ignored outside the i_exec_done cycle in S_ISSUE.
- S_HALT: o_halted=1. S_ERR: o_addr_err=1. Both are terminal; only reset exits them.
- o_next_pc is driven combinationally at all times; it is meaningful only while o_pc_en=1.

## Timing
- Reset values: state=S_IDLE; o_pc_en=0, o_imem_req=0, o_inst=0, o_inst_valid=0, o_halted=0, o_addr_err=0. o_next_pc follows i_pc+4.
- Reset asserted mid-operation: returns to S_IDLE immediately and drops all outputs. No partial PC write is issued.
- Cycle numbering (cycle 0 = first clock edge after reset release):
  - Cycle 0: S_IDLE.
  - Cycle 1: S_REQ.
  - Cycles 2..1+IMEM_LAT: S_WAIT.
  - From cycle 2+IMEM_LAT: o_inst_valid=1.
- Per-instruction loop with no stall: ISSUE (done) → REQ → WAIT×IMEM_LAT → ISSUE, i.e. 2+IMEM_LAT cycles.
- The PC register updates on the edge that ends the o_pc_en cycle, so i_pc is new in the S_REQ cycle.
- o_inst_valid falls in the cycle after i_exec_done is accepted.

## Structure
- Shared package: state encoding enum, INST_BYTES=4, the default IMEM_BYTES, and the latency-counter width (3 bits).
- One natural sub-module: `next_pc_gen`, a combinational block that computes sequential/branch select, wrap-around add and the legality check. It outputs next_pc and illegal. The FSM, latency counter and instruction register stay in the top level.

## Test plan
- Reset, IMEM_LAT=1, i_pc=0, rdata=0x00500093: o_imem_req=1 at cycle 1; o_inst_valid=1 with o_inst=0x00500093 at cycle 3. All outputs are 0 during reset.
- Sequential: i_pc=0x10, exec_done with no branch → o_pc_en pulse, o_next_pc=0x14, o_imem_addr=0x14 in the next cycle.
- Branch: i_pc=0x20, branch_taken=1, target=0x40 → o_next_pc=0x40. Repeat with IMEM_LAT=3 to check the 5-cycle loop.
- Illegal target: target=0x42 or 0x1000 (IMEM_BYTES=4096) → no o_pc_en; o_addr_err=1 and sticky; o_imem_req stays 0 afterwards.
- Halt with branch_taken=1 in the same cycle → halt wins: o_halted=1, no o_pc_en, o_inst_valid=0 from the next cycle.
- Reset asserted during S_WAIT → all outputs 0 immediately; after release, fetch restarts from the current i_pc with no spurious o_pc_en.
